// File: rtl/seq_mul_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : seq_mul_pkg                                               |
// | Purpose  : FSM encoding and sizing helpers for seq_mul_signed        |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package seq_mul_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_NEG  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_CALC = ST_CALC,
        S_NEG  = ST_NEG,
        S_DONE = ST_DONE
    } state_t;

    function automatic int cnt_width(input int n);
        return $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_mul_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : seq_mul_datapath                                          |
// | Purpose  : operand magnitude capture, shift-add accumulate, negate   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module seq_mul_datapath
    import seq_mul_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           step,
    input  logic           negate,
    input  logic           signed_mode,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           mplier_rest_zero,
    output logic           neg,
    output logic [2*N-1:0] acc_next
);

    logic [2*N-1:0] mcand_q, mcand_d;
    logic [N-1:0]   mplier_q, mplier_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic           neg_q, neg_d;
    logic [N-1:0]   w_a_abs, w_b_abs;

    // Negating the most negative value wraps to 2^(N-1), which is exact as unsigned.
    assign w_a_abs = (signed_mode && a[N-1]) ? -a : a;
    assign w_b_abs = (signed_mode && b[N-1]) ? -b : b;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        if (load) begin
            mcand_d  = {{N{1'b0}}, w_a_abs};
            mplier_d = w_b_abs;
            acc_d    = '0;
            neg_d    = signed_mode & (a[N-1] ^ b[N-1]);
        end else if (step) begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end else if (negate) begin
            acc_d    = -acc_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
        end
    end

    assign mplier_rest_zero = (mplier_q[N-1:1] == '0);
    assign neg              = neg_q;
    assign acc_next         = acc_d;

endmodule
`default_nettype wire

// File: rtl/seq_mul_signed.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : seq_mul_signed                                            |
// | Purpose  : signed/unsigned shift-add sequential multiplier           |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module seq_mul_signed
    import seq_mul_pkg::*;
#(
    parameter int N          = 8,
    parameter int EARLY_TERM = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic           ready,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int             CNT_W      = cnt_width(N);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(N - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*N-1:0]   product_q, product_d;
    logic             w_load, w_step, w_negate;
    logic             w_rest_zero, w_neg;
    logic [2*N-1:0]   w_acc_next;

    seq_mul_datapath #(
        .N (N)
    ) u_datapath (
        .clk              (clk),
        .rst              (rst),
        .load             (w_load),
        .step             (w_step),
        .negate           (w_negate),
        .signed_mode      (signed_mode),
        .a                (A),
        .b                (B),
        .mplier_rest_zero (w_rest_zero),
        .neg              (w_neg),
        .acc_next         (w_acc_next)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        w_load    = 1'b0;
        w_step    = 1'b0;
        w_negate  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    w_load  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                w_step = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
                // Exit test looks at the multiplier before this cycle's shift.
                if ((cnt_q == C_CNT_LAST) || ((EARLY_TERM != 0) && w_rest_zero)) begin
                    if (w_neg) begin
                        state_d = S_NEG;
                    end else begin
                        state_d   = S_DONE;
                        product_d = w_acc_next;
                    end
                end
            end
            S_NEG: begin
                w_negate  = 1'b1;
                state_d   = S_DONE;
                product_d = w_acc_next;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign ready   = (state_q == S_IDLE);
    assign done    = (state_q == S_DONE);
    assign product = product_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_mul_signed.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_seq_mul_signed                                         |
// | Purpose  : directed self-checking bench, N=8, both EARLY_TERM modes  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_seq_mul_signed;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic        signed_mode = 1'b0;
    logic [7:0]  A = 8'd0;
    logic [7:0]  B = 8'd0;
    logic        ready0, done0, ready1, done1;
    logic [15:0] product0, product1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_mul_signed #(.N(8), .EARLY_TERM(0)) dut0 (
        .clk(clk), .rst(rst_n), .start(start0), .signed_mode(signed_mode),
        .A(A), .B(B), .ready(ready0), .done(done0), .product(product0)
    );

    seq_mul_signed #(.N(8), .EARLY_TERM(1)) dut1 (
        .clk(clk), .rst(rst_n), .start(start1), .signed_mode(signed_mode),
        .A(A), .B(B), .ready(ready1), .done(done1), .product(product1)
    );

    // Launches one operation on the selected instance and observes 16 cycles.
    // Cycle numbers follow the convention that the accept edge ends cycle 0.
    task automatic run_op(input bit et, input logic [7:0] a, input logic [7:0] b,
                          input bit sm, input bit poke, output int dcyc,
                          output logic [15:0] prod, output int dcnt, output bit rdy_back);
        A = a; B = b; signed_mode = sm;
        if (et) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        dcyc = -1; dcnt = 0; prod = 16'd0; rdy_back = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            @(posedge clk); #1;
            if (poke && e == 2) begin
                A = 8'd2; B = 8'd3; signed_mode = ~sm;
                if (et) start1 = 1'b1; else start0 = 1'b1;
            end
            if (poke && e == 3) begin
                start0 = 1'b0; start1 = 1'b0;
            end
            if (dcyc > 0 && e == dcyc) rdy_back = et ? ready1 : ready0;
            if (et ? done1 : done0) begin
                dcnt++;
                if (dcyc < 0) begin
                    dcyc = e + 1;
                    prod = et ? product1 : product0;
                end
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL reset_ready0 got %b want 1", ready0); end
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done0 got %b want 0", done0); end
        checks++; if (product0 !== 16'd0) begin errors++; $display("FAIL reset_product0 got %h want 0000", product0); end
        checks++; if (ready1 !== 1'b1 || done1 !== 1'b0 || product1 !== 16'd0) begin
            errors++; $display("FAIL reset_dut1 got r=%b d=%b p=%h want r=1 d=0 p=0000", ready1, done1, product1);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned_full;
        int dc, n; logic [15:0] p; bit rb;
        run_op(1'b0, 8'd13, 8'd11, 1'b0, 1'b0, dc, p, n, rb);
        checks++; if (p !== 16'd143) begin errors++; $display("FAIL u13x11_product got %0d want 143", p); end
        checks++; if (dc !== 9) begin errors++; $display("FAIL u13x11_done_cycle got %0d want 9", dc); end
        checks++; if (n !== 1) begin errors++; $display("FAIL u13x11_done_count got %0d want 1", n); end
        checks++; if (rb !== 1'b1) begin errors++; $display("FAIL u13x11_ready_back got %b want 1", rb); end
        run_op(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, dc, p, n, rb);
        checks++; if (p !== 16'hFE01) begin errors++; $display("FAIL u255x255_product got %h want fe01", p); end
        checks++; if (dc !== 9) begin errors++; $display("FAIL u255x255_done_cycle got %0d want 9", dc); end
    endtask

    task automatic test_signed;
        int dc, n; logic [15:0] p; bit rb;
        run_op(1'b1, 8'hFD, 8'h05, 1'b1, 1'b0, dc, p, n, rb);
        checks++; if (p !== 16'hFFF1) begin errors++; $display("FAIL sm3x5_product got %h want fff1", p); end
        checks++; if (dc !== 5) begin errors++; $display("FAIL sm3x5_done_cycle got %0d want 5", dc); end
        run_op(1'b1, 8'h80, 8'h80, 1'b1, 1'b0, dc, p, n, rb);
        checks++; if (p !== 16'h4000) begin errors++; $display("FAIL sm128xm128_product got %h want 4000", p); end
        checks++; if (dc !== 9) begin errors++; $display("FAIL sm128xm128_done_cycle got %0d want 9", dc); end
        run_op(1'b0, 8'h64, 8'hFF, 1'b1, 1'b0, dc, p, n, rb);
        checks++; if (p !== 16'hFF9C) begin errors++; $display("FAIL s100xm1_product got %h want ff9c", p); end
        checks++; if (dc !== 10) begin errors++; $display("FAIL s100xm1_done_cycle got %0d want 10", dc); end
    endtask

    task automatic test_early_term;
        int dc, n; logic [15:0] p; bit rb;
        run_op(1'b1, 8'd200, 8'd1, 1'b0, 1'b0, dc, p, n, rb);
        checks++; if (p !== 16'd200) begin errors++; $display("FAIL et200x1_product got %0d want 200", p); end
        checks++; if (dc !== 2) begin errors++; $display("FAIL et200x1_done_cycle got %0d want 2", dc); end
        run_op(1'b1, 8'd200, 8'd0, 1'b0, 1'b0, dc, p, n, rb);
        checks++; if (p !== 16'd0) begin errors++; $display("FAIL et200x0_product got %0d want 0", p); end
        checks++; if (dc !== 2) begin errors++; $display("FAIL et200x0_done_cycle got %0d want 2", dc); end
        run_op(1'b1, 8'hFB, 8'h00, 1'b1, 1'b0, dc, p, n, rb);
        checks++; if (p !== 16'd0) begin errors++; $display("FAIL etm5x0_product got %h want 0000", p); end
        checks++; if (dc !== 3) begin errors++; $display("FAIL etm5x0_done_cycle got %0d want 3", dc); end
    endtask

    task automatic test_start_ignored;
        int dc, n; logic [15:0] p; bit rb;
        run_op(1'b0, 8'd13, 8'd11, 1'b0, 1'b1, dc, p, n, rb);
        checks++; if (p !== 16'd143) begin errors++; $display("FAIL ignored_start_product got %0d want 143", p); end
        checks++; if (n !== 1) begin errors++; $display("FAIL ignored_start_done_count got %0d want 1", n); end
        checks++; if (dc !== 9) begin errors++; $display("FAIL ignored_start_done_cycle got %0d want 9", dc); end
    endtask

    task automatic test_reset_mid_op;
        int dc, n, nd; logic [15:0] p; bit rb;
        A = 8'd13; B = 8'd11; signed_mode = 1'b0; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", ready0); end
        checks++; if (product0 !== 16'd0) begin errors++; $display("FAIL midrst_product got %h want 0000", product0); end
        checks++; if (product1 !== 16'd0) begin errors++; $display("FAIL midrst_product1 got %h want 0000", product1); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done0) nd++;
        end
        checks++; if (nd !== 0) begin errors++; $display("FAIL midrst_no_done got %0d want 0", nd); end
        run_op(1'b0, 8'd7, 8'd9, 1'b0, 1'b0, dc, p, n, rb);
        checks++; if (p !== 16'd63) begin errors++; $display("FAIL after_rst_7x9 got %0d want 63", p); end
        checks++; if (dc !== 9) begin errors++; $display("FAIL after_rst_done_cycle got %0d want 9", dc); end
    endtask

    initial begin
        test_reset();
        test_unsigned_full();
        test_signed();
        test_early_term();
        test_start_ignored();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_mul_signed.md
# seq_mul_signed

Parametrised shift-add sequential multiplier with a selectable signed/unsigned mode, optional early termination, and a start/ready/done handshake. It replaces the fixed-width unsigned multiplier in the `dsd/multiplier` datapath. It multiplies two N-bit operands into a 2N-bit product over several cycles and holds the result until the next operation completes.

## Interface
- `N`, default 8: operand width; legal range N ≥ 2.
- `EARLY_TERM`, default 1: 1 = stop iterating once the remaining multiplier bits are all zero; 0 = always run N iterations.

- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `start`  in  1: request; accepted only on a cycle where `ready`=1.
- `signed_mode`  in  1: 1 = operands are two's complement; 0 = unsigned. Sampled at accept.
- `A`  in  N: multiplicand, sampled at accept.
- `B`  in  N: multiplier, sampled at accept.
- `ready`  out  1: idle and able to accept.
- `done`  out  1: one-cycle pulse; `product` is valid in the same cycle.
- `product`  out  2N: registered result, held until the next `done`.

## Operation
- States: IDLE, CALC, NEG, DONE.
- IDLE:
  - `ready`=1.
  - When `start`=1, capture operands and go to CALC.
  - `start` in any other state is ignored; it is not queued.
- Capture:
  - Unsigned: `mcand` = zero-extend(A) to 2N bits, `mplier` = B, `neg`=0.
  - Signed: `mcand` = |A| zero-extended, `mplier` = |B|, `neg` = A[N-1]^B[N-1].
  - |−2^(N−1)| = 2^(N−1) fits in N unsigned bits; no overflow.
  - Clear `acc` (2N bits) and `cnt` (width $clog2(N)).
- CALC, once per cycle:
  - If `mplier[0]`, then `acc` += `mcand` (mod 2^2N).
  - `mcand` <<= 1, `mplier` >>= 1, `cnt`++.
- Exit CALC after the current iteration when `cnt`==N−1, or when EARLY_TERM=1 and `mplier[N-1:1]`==0.
  - Next state is NEG if `neg`=1, otherwise DONE.
  - CALC always runs at least one cycle, including when B=0.
- NEG: `acc` = two's-complement negation of `acc` (2N bits), then go to DONE.
- DONE:
  - Load `acc` into `product`, assert `done` for this cycle only, then go to IDLE.
  - `ready`=0 during DONE.
- Signed result is exact two's complement over 2N bits.
  - (−2^(N−1))·(−2^(N−1)) = 2^(2N−2), which is representable.
  - Zero times a negative operand gives 0; negating 0 gives 0.
- Reset values: state=IDLE, `ready`=1, `done`=0, `product`=0, all internal registers 0.
- Reset asserted mid-operation:
  - Immediately abort and return to IDLE.
  - `product` goes to 0; no `done` pulse is issued for the aborted operation.

## Timing
- Cycle 0 is the edge where `start`·`ready` is sampled; `ready` falls after that edge.
- Iteration count K:
  - K = N when EARLY_TERM=0.
  - When EARLY_TERM=1, K = max(1, bit position of the highest set bit of `mplier`, counted from 1).
- `done`=1 during cycle K+1, or K+2 if NEG is used.
- `ready` returns to 1 in the cycle after `done`.
  - A new `start` there gives back-to-back operations with one idle cycle between `done` pulses.
- `product` changes only on the edge that enters DONE, or on reset.

## Structure
- Package `seq_mul_pkg` holds:
  - the `state_t` enum (IDLE, CALC, NEG, DONE);
  - the 2-bit state encoding constants;
  - a function for the counter width, $clog2(N).
- Sub-module `seq_mul_datapath` holds `mcand`, `mplier`, `acc` and `neg`, and the abs/negate logic.
  - Control inputs: `load`, `step`, `negate`.
  - Status output: `mplier_rest_zero`.
- Top level: FSM, `cnt`, and the `product` register.

## Test plan
All scenarios use N=8.
- Unsigned 13×11, EARLY_TERM=0 -> `product`=16'd143, `done` in cycle 9, `ready` back in cycle 10.
- Signed −3×5 (8'hFD, 8'h05), EARLY_TERM=1 -> K=3, NEG used, `product`=16'hFFF1, `done` in cycle 5.
- Signed −128×−128 -> `product`=16'h4000, no NEG. Unsigned 255×255 -> 16'hFE01.
- EARLY_TERM=1, A=200, B=1 -> `done` in cycle 2, `product`=16'd200. B=0 -> `done` in cycle 2, `product`=0.
- `start` pulsed with different operands during CALC -> ignored; the result matches the first operands only, and there is exactly one `done`.
- `rst` low in cycle 3 of an operation -> `ready`=1, `product`=0, no `done`. The next operation 7×9 -> 16'd63.
